// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and latency helpers for the systolic array sequencer
package systolic_pkg;

   localparam int DATAWIDTH_DEF        = 8;
   localparam int DATAWIDTH_OUTPUT_DEF = 32;
   localparam int N_SIZE_DEF           = 32;
   localparam int PIPE_LAT             = 2*N_SIZE_DEF+1;

   typedef logic [DATAWIDTH_DEF-1:0]        elem_t;
   typedef logic [DATAWIDTH_OUTPUT_DEF-1:0] psum_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   // Accept-to-c_valid latency for an array of dimension n.
   function automatic int pipe_lat(input int n);
      return 2*n+1;
   endfunction

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - fixed-depth register delay line; DEPTH=0 is a plain wire
module skew_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign q = d;
      end else begin : g_pipe
         logic [WIDTH-1:0] pipe [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= d;
               for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign q = pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - weight-stationary systolic array sequencer: weight load, input skew, output deskew
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int DATAWIDTH        = 8,
   parameter int DATAWIDTH_output = 32,
   parameter int N_SIZE           = 32,
   parameter int VEC_W            = 9
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [VEC_W-1:0]                       num_vecs,
   output logic                                   busy,
   output logic                                   done,
   input  logic                                   w_valid,
   output logic                                   w_ready,
   input  logic                                   a_valid,
   output logic                                   a_ready,
   input  logic [N_SIZE-1:0][DATAWIDTH-1:0]        a_data,
   output logic                                   c_valid,
   output logic                                   c_last,
   output logic [N_SIZE-1:0][DATAWIDTH_output-1:0] c_data,
   output logic                                   arr_wt_en,
   output logic                                   arr_valid_in,
   output logic [N_SIZE-1:0][DATAWIDTH-1:0]        arr_matrix_A,
   output logic [N_SIZE-1:0][DATAWIDTH_output-1:0] arr_matrix_B,
   input  logic [N_SIZE-1:0][DATAWIDTH_output-1:0] arr_matrix_C
);

   localparam int LAT = pipe_lat(N_SIZE);

   state_t state, state_n;
   logic [VEC_W-1:0] nv_q;
   logic [VEC_W-1:0] acc_cnt;
   logic [VEC_W-1:0] pend;
   logic             accept;
   logic             last_acc;
   logic [1:0]       tag_q;

   logic [N_SIZE-1:0][DATAWIDTH-1:0]        a_reg;
   logic [N_SIZE-1:0][DATAWIDTH_output-1:0] deskew;

   assign accept       = a_valid && a_ready;
   assign last_acc     = accept && ((acc_cnt + VEC_W'(1)) == nv_q);
   assign arr_matrix_B = '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n      = state;
      busy         = 1'b1;
      done         = 1'b0;
      w_ready      = 1'b0;
      arr_wt_en    = 1'b0;
      a_ready      = 1'b0;
      arr_valid_in = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_n = LOAD_W;
         end
         LOAD_W: begin
            w_ready   = w_valid;
            arr_wt_en = w_valid;
            if (w_valid) state_n = (nv_q == '0) ? DRAIN : STREAM;
         end
         STREAM: begin
            arr_valid_in = 1'b1;
            a_ready      = (acc_cnt != nv_q);
            if (last_acc) state_n = DRAIN;
         end
         DRAIN: begin
            arr_valid_in = 1'b1;
            if (pend == '0) state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // pend counts vectors accepted but not yet emitted, i.e. tags still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nv_q    <= '0;
         acc_cnt <= '0;
         pend    <= '0;
         a_reg   <= '0;
         c_data  <= '0;
      end else begin
         if (state == IDLE && start) begin
            nv_q    <= num_vecs;
            acc_cnt <= '0;
         end else if (accept) begin
            acc_cnt <= acc_cnt + VEC_W'(1);
         end
         if (accept && !c_valid)      pend <= pend + VEC_W'(1);
         else if (!accept && c_valid) pend <= pend - VEC_W'(1);
         a_reg  <= accept ? a_data : '0;
         c_data <= deskew;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_SIZE; g++) begin : g_lane
         skew_line #(.WIDTH(DATAWIDTH), .DEPTH(g)) u_skew (
            .clk (clk),
            .rst (rst),
            .d   (a_reg[g]),
            .q   (arr_matrix_A[g])
         );
         skew_line #(.WIDTH(DATAWIDTH_output), .DEPTH(N_SIZE-1-g)) u_deskew (
            .clk (clk),
            .rst (rst),
            .d   (arr_matrix_C[g]),
            .q   (deskew[g])
         );
      end
   endgenerate

   // Tag travels alongside the data so bubbles never raise c_valid.
   skew_line #(.WIDTH(2), .DEPTH(LAT)) u_tag (
      .clk (clk),
      .rst (rst),
      .d   ({accept, last_acc}),
      .q   (tag_q)
   );

   assign c_valid = tag_q[1];
   assign c_last  = tag_q[0];

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the weight-stationary systolic array.
- Accepts a start command and a weight tile, then pulses the array's weight-load enable.
- Streams input vectors into the array rows with per-row skew.
- De-skews the column outputs and emits one aligned result vector per accepted input vector, with valid and last flags.
- Sits between the tile buffers (weight buffer, activation FIFO, output buffer) and the array instance.

Parameters:
- DATAWIDTH, 8, activation/weight element width
- DATAWIDTH_output, 32, partial-sum/result element width
- N_SIZE, 32, array dimension (rows = columns)
- VEC_W, 9, width of the vector-count field (max 2^VEC_W-1 vectors per tile)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin tile operation (sampled in IDLE only)
- num_vecs  in  VEC_W  input vectors in this tile, latched on start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- w_valid  in  1  weight tile stable on the array's weight bus
- w_ready  out  1  weight tile consumed this cycle
- a_valid  in  1  input vector available
- a_ready  out  1  input vector accepted when a_valid&&a_ready
- a_data  in  DATAWIDTH x N_SIZE  input vector, element i feeds row i
- c_valid  out  1  aligned result vector valid
- c_last  out  1  with c_valid: final vector of tile
- c_data  out  DATAWIDTH_output x N_SIZE  result, element k from column k
- arr_wt_en  out  1  to array wt_en
- arr_valid_in  out  1  to array valid_in
- arr_matrix_A  out  DATAWIDTH x N_SIZE  to array matrix_A (skewed)
- arr_matrix_B  out  DATAWIDTH_output x N_SIZE  to array matrix_B; constant 0
- arr_matrix_C  in  DATAWIDTH_output x N_SIZE  from array matrix_C

Behaviour:
- Reset (async, any state): FSM->IDLE; counters, skew, deskew and tag pipelines cleared. All outputs 0; a_ready=0, w_ready=0.
- FSM states:
  - IDLE: busy=0. On start, latch num_vecs and go to LOAD_W.
  - LOAD_W: w_ready=w_valid. On w_valid, arr_wt_en=1 for exactly that cycle. Next state is STREAM, or DRAIN if num_vecs==0.
  - STREAM: a_ready=1 until num_vecs vectors are accepted. Go to DRAIN in the cycle after the final acceptance.
  - DRAIN: a_ready=0. Wait until the tag pipeline is empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored while busy.
- arr_valid_in=1 from STREAM entry through the last DRAIN cycle; 0 otherwise.
- Input skew:
  - Element i of the accepted vector passes through a register plus an i-cycle delay line.
  - If vector j is accepted in cycle t, element i appears on arr_matrix_A[i] at t+1+i.
  - Cycles with no acceptance (bubble) inject 0 on every row.
- Array timing: column k result for vector j arrives on arr_matrix_C[k] at t+1+N_SIZE+k.
- Output deskew:
  - Column k is delayed by N_SIZE-1-k cycles, so all columns align at t+2*N_SIZE.
  - c_data is registered; c_valid for vector j asserts at t+2*N_SIZE+1.
- Tag pipeline: a 1-bit valid tag plus a last flag enter with each accepted vector and travel a depth-matched shift register. c_valid and c_last come only from the tag, so bubbles never produce c_valid.
- The output consumer has no backpressure and must accept every c_valid.
- c_last=1 only on the vector accepted when the accepted count reaches num_vecs.
- num_vecs==0: weights still load, no c_valid is produced, done follows the empty drain.
- A second start during busy has no effect; the next tile requires IDLE.
- Counter width is VEC_W; there is no wrap because acceptance stops at num_vecs.

Decomposition:
- Package systolic_pkg:
  - state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE)
  - localparam PIPE_LAT = 2*N_SIZE+1
  - element typedefs for DATAWIDTH and DATAWIDTH_output words
- Sub-module skew_line (parameters WIDTH, DEPTH; DEPTH=0 is a wire). It is generated per row for input skew and per column for deskew. The tag pipeline is one instance with DEPTH=PIPE_LAT.

Test Plan (N_SIZE=4):
- Identity weights, num_vecs=3, a_data {1,2,3,4},{5,6,7,8},{9,10,11,12} back-to-back from cycle t -> c_valid at t+9, t+10, t+11; c_data equals inputs; c_last only on the third; done pulses once; busy falls with done.
- All-ones weights, vector {1,2,3,4} -> every c_data element = 10.
- Same as case 1 with a_valid low for 2 cycles between vectors 1 and 2 -> 2-cycle gap in c_valid, no spurious c_valid, values unchanged.
- num_vecs=0 -> exactly one arr_wt_en pulse, zero c_valid, done asserted.
- rst asserted in STREAM after 1 vector -> all outputs 0 immediately, no c_valid afterwards; a new start completes normally.
- start pulsed during DRAIN -> ignored: one done only, num_vecs latch unchanged.
